alu_mc: RTL
===========

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits (legal values 8, 16, 32, 64).
REQ-002 Parameter: SHW, 5, shift-amount width; SHALL equal clog2(WIDTH).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: in_valid  input  1  request valid.
REQ-006 Port: in_ready  output  1  block accepts a request this cycle.
REQ-007 Port: in0  input  WIDTH  operand A.
REQ-008 Port: in1  input  WIDTH  operand B.
REQ-009 Port: ALUCtrl  input  4  operation select.
REQ-010 Port: shamt  input  SHW  shift amount.
REQ-011 Port: out_valid  output  1  result valid.
REQ-012 Port: out_ready  input  1  consumer takes result this cycle.
REQ-013 Port: ALUResult  output  WIDTH  result, or product low half, or quotient.
REQ-014 Port: hi  output  WIDTH  product high half or remainder; 0 for other ops.
REQ-015 Port: Zero  output  1  ALUResult == 0.
REQ-016 Port: ovf  output  1  signed overflow for ADD/SUB; 0 for other ops.

Function
REQ-017 Encodings SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0100 SLL (in1<<shamt), 0101 SRL (in1>>shamt, logical), 1100 SRA (in1>>>shamt), 0111 SLT (signed in0<in1 -> 1, else 0), 1000 MULTU, 1001 DIVU; any other code SHALL yield ALUResult=0, hi=0, ovf=0.
REQ-018 FSM states SHALL be IDLE, MUL, DIV, DONE; in_ready SHALL be 1 only in IDLE.
REQ-019 A request SHALL be accepted when in_valid && in_ready; operands, ALUCtrl and shamt SHALL be captured at that edge and later input changes SHALL be ignored.
REQ-020 Single-cycle ops (all except MULTU/DIVU) SHALL move IDLE->DONE, with out_valid=1 on the cycle after acceptance (latency 1).
REQ-021 MULTU SHALL be an unsigned iterative shift-add over WIDTH cycles in MUL, then DONE; out_valid SHALL assert exactly WIDTH+1 cycles after acceptance; {hi,ALUResult} = full 2*WIDTH-bit product.
REQ-022 DIVU SHALL be an unsigned restoring divide over WIDTH cycles in DIV, then DONE; out_valid exactly WIDTH+1 cycles after acceptance; ALUResult=quotient, hi=remainder.
REQ-023 DIVU with in1==0 SHALL skip DIV and go IDLE->DONE (latency 1) with ALUResult=all-ones, hi=in0.
REQ-024 Iteration counter SHALL be clog2(WIDTH)+1 bits, count 0..WIDTH-1, and leave MUL/DIV on the terminal count.
REQ-025 ADD/SUB results SHALL wrap modulo 2^WIDTH; ovf=1 when operand signs (after negating in1 for SUB) match and the result sign differs.
REQ-026 In DONE, outputs SHALL be held stable while out_ready=0; on out_valid && out_ready the FSM SHALL return to IDLE next cycle, out_valid then 0.
REQ-027 in_valid while not in IDLE SHALL be ignored without corrupting the operation in flight.
REQ-028 Zero SHALL be computed from the registered ALUResult and valid whenever out_valid=1.
REQ-029 shamt SHALL be used as-is; shift by 0 SHALL return in1 unchanged.

Reset
REQ-030 rst_n=0 at a rising edge SHALL force IDLE, counter=0, out_valid=0, ALUResult=0, hi=0, Zero=1, ovf=0; in_ready=1 from the first cycle after rst_n returns to 1.
REQ-031 Reset during MUL, DIV or DONE SHALL abandon the operation; no out_valid SHALL be produced for it.

Verification (WIDTH=32)
REQ-032 ADD 0x7FFFFFFF+0x00000001 -> next cycle out_valid=1, ALUResult=0x80000000, ovf=1, Zero=0.
REQ-033 SUB 5-5 -> ALUResult=0, Zero=1, ovf=0; SRA in1=0x80000000, shamt=4 -> 0xF8000000.
REQ-034 MULTU 0xFFFFFFFF*0x00000002 -> out_valid exactly 33 cycles after accept, hi=0x00000001, ALUResult=0xFFFFFFFE; in_ready=0 throughout.
REQ-035 DIVU 100/7 -> after 33 cycles ALUResult=14, hi=2; DIVU 9/0 -> next cycle ALUResult=0xFFFFFFFF, hi=9.
REQ-036 Single-cycle op with out_ready held 0 for 5 cycles -> outputs unchanged, in_ready=0; a new in_valid in that window is dropped.
REQ-037 rst_n=0 on cycle 10 of MULTU -> next cycle out_valid=0, in_ready=1 after release, a following ADD 2+3 returns 5.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle ALU with a valid/ready request side and a valid/ready result side.
// Logic, arithmetic, shift and compare ops finish in one cycle. MULTU is an
// iterative shift-add and DIVU is an iterative restoring divide, each taking
// WIDTH steps.
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready.
// A result transfers on a rising edge where out_valid && out_ready. Once
// asserted, out_valid stays high and the outputs stay unchanged until that
// transfer happens. in_ready is high only when the block is idle.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [3:0]       ALUCtrl,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic [WIDTH-1:0] hi,
    output logic             Zero,
    output logic             ovf,
    output logic [1:0]       state_dbg
);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLL   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_SRA   = 4'b1100;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;

    localparam int              CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic             accept;
    logic             last_step;
    logic [CW-1:0]    cnt;

    // Operand held for the iterative ops: multiplicand for MULTU, divisor for DIVU.
    logic [WIDTH-1:0] opa;
    // Working pair: {upper, lower} product for MULTU, {remainder, quotient} for DIVU.
    logic [WIDTH-1:0] w_hi, w_lo;

    logic [WIDTH-1:0] res_lo, res_hi;
    logic             res_ovf;

    logic [WIDTH-1:0] add_sum, sub_diff;
    logic [WIDTH-1:0] sc_lo, sc_hi;
    logic             sc_ovf;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift, div_diff;
    logic [WIDTH-1:0] step_hi, step_lo;

    assign accept    = in_valid && in_ready;
    assign last_step = (cnt == LAST);
    assign add_sum   = in0 + in1;
    assign sub_diff  = in0 - in1;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; DIVU by zero is resolved immediately without iterating.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (ALUCtrl == OP_MULTU)                        state_nxt = MUL;
                    else if (ALUCtrl == OP_DIVU && in1 != '0)       state_nxt = DIV;
                    else                                            state_nxt = DONE;
                end
            end
            MUL:  if (last_step) state_nxt = DONE;
            DIV:  if (last_step) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode from state.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        state_dbg = state;
    end

    // Single-cycle result, computed from the live inputs and registered on acceptance.
    always_comb begin
        sc_lo  = '0;
        sc_hi  = '0;
        sc_ovf = 1'b0;
        case (ALUCtrl)
            OP_AND: sc_lo = in0 & in1;
            OP_OR:  sc_lo = in0 | in1;
            OP_ADD: begin
                sc_lo  = add_sum;
                sc_ovf = (in0[WIDTH-1] == in1[WIDTH-1]) && (add_sum[WIDTH-1] != in0[WIDTH-1]);
            end
            OP_SUB: begin
                sc_lo  = sub_diff;
                sc_ovf = (in0[WIDTH-1] != in1[WIDTH-1]) && (sub_diff[WIDTH-1] != in0[WIDTH-1]);
            end
            OP_SLL: sc_lo = in1 << shamt;
            OP_SRL: sc_lo = in1 >> shamt;
            OP_SRA: sc_lo = $signed(in1) >>> shamt;
            OP_SLT: sc_lo = {{(WIDTH-1){1'b0}}, ($signed(in0) < $signed(in1))};
            OP_DIVU: begin
                // Only reaches the output when the divisor is zero.
                sc_lo = '1;
                sc_hi = in0;
            end
            default: begin
                sc_lo  = '0;
                sc_hi  = '0;
                sc_ovf = 1'b0;
            end
        endcase
    end

    // One iteration step of shift-add multiply or restoring divide.
    always_comb begin
        mul_sum   = {1'b0, w_hi} + (w_lo[0] ? {1'b0, opa} : '0);
        div_shift = {w_hi, w_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opa};
        step_hi   = w_hi;
        step_lo   = w_lo;
        if (state == MUL) begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], w_lo[WIDTH-1:1]};
        end else if (state == DIV) begin
            if (!div_diff[WIDTH]) begin
                step_hi = div_diff[WIDTH-1:0];
                step_lo = {w_lo[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_shift[WIDTH-1:0];
                step_lo = {w_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Datapath: capture on acceptance, iterate in MUL/DIV, hold results in DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            opa     <= '0;
            w_hi    <= '0;
            w_lo    <= '0;
            res_lo  <= '0;
            res_hi  <= '0;
            res_ovf <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt     <= '0;
                        opa     <= (ALUCtrl == OP_MULTU) ? in0 : in1;
                        w_hi    <= '0;
                        w_lo    <= (ALUCtrl == OP_MULTU) ? in1 : in0;
                        res_lo  <= sc_lo;
                        res_hi  <= sc_hi;
                        res_ovf <= sc_ovf;
                    end
                end
                MUL, DIV: begin
                    w_hi <= step_hi;
                    w_lo <= step_lo;
                    if (last_step) begin
                        cnt     <= '0;
                        res_lo  <= step_lo;
                        res_hi  <= step_hi;
                        res_ovf <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign ALUResult = res_lo;
    assign hi        = res_hi;
    assign ovf       = res_ovf;
    assign Zero      = (res_lo == '0);

endmodule
